// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline boundary with operand bypass, load-use bubble and IF/ID hold.
// Optional STALL_CNT_EN adds a saturating count of load-use bubbles on o_stall_cnt.
module id_ex_stage #(
  parameter int DW    = 16,
  parameter int RAW   = 3,
  parameter int CTRLW = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_id_valid,
  input  logic [RAW-1:0]   i_id_rs,
  input  logic [RAW-1:0]   i_id_rt,
  input  logic             i_id_rt_used,
  input  logic [RAW-1:0]   i_id_rd,
  input  logic             i_id_we,
  input  logic             i_id_is_load,
  input  logic [DW-1:0]    i_id_imm,
  input  logic [DW-1:0]    i_id_pc,
  input  logic [CTRLW-1:0] i_id_ctrl,
  input  logic [DW-1:0]    i_rs_data,
  input  logic [DW-1:0]    i_rt_data,
  input  logic             i_exm_we,
  input  logic [RAW-1:0]   i_exm_rd,
  input  logic [DW-1:0]    i_exm_data,
  input  logic             i_wb_we,
  input  logic [RAW-1:0]   i_wb_rd,
  input  logic [DW-1:0]    i_wb_data,
  input  logic             i_ex_hold,
  input  logic             i_flush,
  output logic             o_id_stall,
  output logic             o_ex_valid,
  output logic             o_ex_we,
  output logic             o_ex_is_load,
  output logic [RAW-1:0]   o_ex_rd,
  output logic [DW-1:0]    o_ex_a,
  output logic [DW-1:0]    o_ex_b,
  output logic [DW-1:0]    o_ex_imm,
  output logic [DW-1:0]    o_ex_pc,
`ifdef STALL_CNT_EN
  output logic [15:0]      o_stall_cnt,
`endif
  output logic [CTRLW-1:0] o_ex_ctrl
);
  logic          w_luh;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  // EX/MEM is younger than MEM/WB, so it wins when both target the same register
  always_comb begin
    w_a = (i_id_rs == '0) ? '0 :
          (i_exm_we && i_exm_rd == i_id_rs) ? i_exm_data :
          (i_wb_we && i_wb_rd == i_id_rs) ? i_wb_data : i_rs_data;
    w_b = (i_id_rt == '0) ? '0 :
          (i_exm_we && i_exm_rd == i_id_rt) ? i_exm_data :
          (i_wb_we && i_wb_rd == i_id_rt) ? i_wb_data : i_rt_data;
    w_luh = i_id_valid && o_ex_valid && o_ex_is_load && o_ex_we && o_ex_rd != '0 &&
            (o_ex_rd == i_id_rs || (i_id_rt_used && o_ex_rd == i_id_rt));
    o_id_stall = (w_luh || i_ex_hold) && !i_flush;
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_ex_valid   <= 1'b0;
      o_ex_we      <= 1'b0;
      o_ex_is_load <= 1'b0;
      o_ex_rd      <= '0;
      o_ex_a       <= '0;
      o_ex_b       <= '0;
      o_ex_imm     <= '0;
      o_ex_pc      <= '0;
      o_ex_ctrl    <= '0;
    end else if (i_flush || (!i_ex_hold && w_luh)) begin
      o_ex_valid   <= 1'b0;
      o_ex_we      <= 1'b0;
      o_ex_is_load <= 1'b0;
    end else if (!i_ex_hold) begin
      o_ex_valid   <= i_id_valid;
      o_ex_we      <= i_id_we && i_id_valid;
      o_ex_is_load <= i_id_is_load && i_id_valid;
      o_ex_rd      <= i_id_rd;
      o_ex_a       <= w_a;
      o_ex_b       <= w_b;
      o_ex_imm     <= i_id_imm;
      o_ex_pc      <= i_id_pc;
      o_ex_ctrl    <= i_id_ctrl;
    end
  end
`ifdef STALL_CNT_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) o_stall_cnt <= '0;
    else if (!i_flush && !i_ex_hold && w_luh && o_stall_cnt != 16'hFFFF) o_stall_cnt <= o_stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of bypass, load-use bubble, flush, hold and async reset.
module tb_id_ex_stage;
  logic        clk = 0, reset_n = 0;
  logic        id_valid = 0, id_rt_used = 0, id_we = 0, id_is_load = 0;
  logic [2:0]  id_rs = 0, id_rt = 0, id_rd = 0, exm_rd = 0, wb_rd = 0;
  logic [15:0] id_imm = 0, id_pc = 0, rs_data = 0, rt_data = 0, exm_data = 0, wb_data = 0;
  logic [7:0]  id_ctrl = 0;
  logic        exm_we = 0, wb_we = 0, ex_hold = 0, flush = 0;
  logic        id_stall, ex_valid, ex_we, ex_is_load;
  logic [2:0]  ex_rd;
  logic [15:0] ex_a, ex_b, ex_imm, ex_pc;
  logic [7:0]  ex_ctrl;
`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int checks = 0, errors = 0;

  id_ex_stage dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_rt_used(id_rt_used), .i_id_rd(id_rd), .i_id_we(id_we), .i_id_is_load(id_is_load),
    .i_id_imm(id_imm), .i_id_pc(id_pc), .i_id_ctrl(id_ctrl), .i_rs_data(rs_data), .i_rt_data(rt_data),
    .i_exm_we(exm_we), .i_exm_rd(exm_rd), .i_exm_data(exm_data), .i_wb_we(wb_we), .i_wb_rd(wb_rd),
    .i_wb_data(wb_data), .i_ex_hold(ex_hold), .i_flush(flush), .o_id_stall(id_stall),
    .o_ex_valid(ex_valid), .o_ex_we(ex_we), .o_ex_is_load(ex_is_load), .o_ex_rd(ex_rd),
    .o_ex_a(ex_a), .o_ex_b(ex_b), .o_ex_imm(ex_imm), .o_ex_pc(ex_pc),
`ifdef STALL_CNT_EN
    .o_stall_cnt(stall_cnt),
`endif
    .o_ex_ctrl(ex_ctrl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {29'd0, ex_valid, ex_we, ex_is_load}, 32'd0);
    chk({tag, "_rd"}, {29'd0, ex_rd}, 32'd0);
    chk({tag, "_ab"}, {ex_a, ex_b}, 32'd0);
    chk({tag, "_imm_pc"}, {ex_imm, ex_pc}, 32'd0);
    chk({tag, "_ctrl"}, {24'd0, ex_ctrl}, 32'd0);
`ifdef STALL_CNT_EN
    chk({tag, "_cnt"}, {16'd0, stall_cnt}, 32'd0);
`endif
  endtask

  initial begin
    #1;
    chk_zero("reset");
    step();
    reset_n = 1;
    // forwarding priority on rs
    id_valid = 1; id_we = 1; id_rd = 5; id_rs = 3; id_rt = 1; id_rt_used = 1;
    rs_data = 16'h1111; rt_data = 16'h2222; id_imm = 16'h1234; id_pc = 16'h0040; id_ctrl = 8'h5A;
    exm_we = 1; exm_rd = 3; exm_data = 16'hAAAA; wb_we = 1; wb_rd = 3; wb_data = 16'hBBBB;
    step();
    chk("fwd_exm_a", {16'd0, ex_a}, 32'h0000AAAA);
    chk("rf_b", {16'd0, ex_b}, 32'h00002222);
    chk("ctl_alu", {29'd0, ex_valid, ex_we, ex_is_load}, 32'b110);
    chk("rd_imm_pc", {5'd0, ex_rd, ex_imm, 8'd0}, {5'd0, 3'd5, 16'h1234, 8'd0});
    chk("pc_ctrl", {ex_pc, 8'd0, ex_ctrl}, {16'h0040, 8'd0, 8'h5A});
    exm_we = 0;
    step();
    chk("fwd_wb_a", {16'd0, ex_a}, 32'h0000BBBB);
    wb_we = 0;
    step();
    chk("rf_a", {16'd0, ex_a}, 32'h00001111);
    // R0 never forwarded; rt from WB
    id_rs = 0; exm_we = 1; exm_rd = 0; exm_data = 16'hFFFF; wb_we = 1; wb_rd = 1; wb_data = 16'h3333;
    rs_data = 16'h7777;
    step();
    chk("r0_zero", {16'd0, ex_a}, 32'h00000000);
    chk("fwd_wb_b", {16'd0, ex_b}, 32'h00003333);
    exm_we = 0; wb_we = 0;
    // asynchronous reset mid-stream
    #2 reset_n = 0;
    #1 chk_zero("async_rst");
    #1 reset_n = 1;
    // load-use: LW R2 then ADD R4,R2,R1
    id_valid = 1; id_is_load = 1; id_we = 1; id_rd = 2; id_rs = 1; id_rt = 0; id_rt_used = 0;
    step();
    chk("lw_ex", {28'd0, ex_valid, ex_is_load, ex_rd[1:0]}, {28'd0, 1'b1, 1'b1, 2'd2});
    id_is_load = 0; id_rd = 4; id_rs = 2; id_rt = 1; id_rt_used = 1; rs_data = 16'h0BAD; rt_data = 16'h0011;
    #1 chk("luh_stall", {31'd0, id_stall}, 32'd1);
    step();
    chk("luh_bubble", {29'd0, ex_valid, ex_we, ex_is_load}, 32'd0);
    chk("luh_stall_drop", {31'd0, id_stall}, 32'd0);
`ifdef STALL_CNT_EN
    chk("cnt_1", {16'd0, stall_cnt}, 32'd1);
`endif
    wb_we = 1; wb_rd = 2; wb_data = 16'hCAFE;
    step();
    chk("add_enter", {29'd0, ex_valid, ex_we, ex_is_load}, 32'b110);
    chk("add_a", {16'd0, ex_a}, 32'h0000CAFE);
    chk("add_rd", {29'd0, ex_rd}, 32'd4);
    wb_we = 0;
    // load then flush of the dependent
    id_is_load = 1; id_rd = 3; id_rs = 1; id_rt_used = 0;
    step();
    id_is_load = 0; id_rd = 4; id_rs = 3; flush = 1;
    #1 chk("flush_nostall", {31'd0, id_stall}, 32'd0);
    step();
    chk("flush_bubble", {29'd0, ex_valid, ex_we, ex_is_load}, 32'd0);
`ifdef STALL_CNT_EN
    chk("cnt_flush", {16'd0, stall_cnt}, 32'd1);
`endif
    flush = 0;
    // rt only matters when rt_used
    id_is_load = 1; id_rd = 6; id_rs = 1;
    step();
    id_is_load = 0; id_rd = 4; id_rs = 1; id_rt = 6; id_rt_used = 0;
    #1 chk("rt_unused", {31'd0, id_stall}, 32'd0);
    id_rt_used = 1;
    #1 chk("rt_used", {31'd0, id_stall}, 32'd1);
    step();
`ifdef STALL_CNT_EN
    chk("cnt_2", {16'd0, stall_cnt}, 32'd2);
`endif
    // hold freezes ID/EX
    id_rd = 7; id_rs = 0; id_rt = 0; id_imm = 16'h00AA; id_pc = 16'h0100; id_ctrl = 8'hC3;
    step();
    chk("pre_hold", {ex_imm, 13'd0, ex_rd}, {16'h00AA, 13'd0, 3'd7});
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      id_rd = 3'(i + 1); id_imm = 16'(i + 16'h0500); id_pc = 16'(i + 16'h0200); id_ctrl = 8'(i);
      #1 chk("hold_stall", {31'd0, id_stall}, 32'd1);
      step();
      chk("hold_imm_pc", {ex_imm, ex_pc}, {16'h00AA, 16'h0100});
      chk("hold_ctl", {20'd0, ex_ctrl, ex_valid, ex_rd}, {20'd0, 8'hC3, 1'b1, 3'd7});
    end
    ex_hold = 0; id_rd = 1; id_imm = 16'hBEEF;
    #1 chk("release_stall", {31'd0, id_stall}, 32'd0);
    step();
    chk("release_cap", {ex_imm, 13'd0, ex_rd}, {16'hBEEF, 13'd0, 3'd1});
    // rd=0 write still propagates; invalid instruction gives no write
    id_rd = 0;
    step();
    chk("rd0_we", {28'd0, ex_valid, ex_we, ex_rd[1:0]}, {28'd0, 1'b1, 1'b1, 2'd0});
    id_valid = 0; id_is_load = 1;
    step();
    chk("invalid", {29'd0, ex_valid, ex_we, ex_is_load}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
